// File: rtl/fifo_row_feeder_if.sv
// FIFO read port and downstream valid/ready stream of one systolic-array row feeder.
interface fifo_row_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_read;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_read, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_read, out_valid, out_data
  );
endinterface

// File: rtl/fifo_row_feeder.sv
// Pops a programmed burst from fifo_mem after a per-row skew delay and streams it to a
// systolic row through a 2-entry skid buffer that hides the FIFO's one-cycle read latency.
module fifo_row_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int SKEW_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [SKEW_WIDTH-1:0] skew,
  output logic                  busy,
  output logic                  done,
  fifo_row_feeder_if.master     bus
);

  typedef enum logic [1:0] {IDLE, SKEW, STREAM, DONE} state_t;

  state_t                         state, state_nxt;
  logic [CNT_WIDTH-1:0]           cnt_r, issued, accepted;
  logic [SKEW_WIDTH-1:0]          skew_r;
  logic [1:0]                     buf_cnt;
  logic [1:0][DATA_WIDTH-1:0]     buf_q;
  logic                           inflight;
  logic                           rd, pop, push;
  logic [1:0]                     occ;

  assign pop  = bus.out_valid && bus.out_ready;
  assign push = inflight;
  // Occupancy after this cycle; the entry leaving now is credited so a full-rate
  // stream keeps one read in flight while one word is being handed downstream.
  assign occ  = buf_cnt + {1'b0, inflight} - {1'b0, pop};

  assign bus.fifo_read = rd;
  assign bus.out_valid = (buf_cnt != 2'd0);
  assign bus.out_data  = buf_q[0];

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count == '0)      state_nxt = DONE;
          else if (skew == '0)  state_nxt = STREAM;
          else                  state_nxt = SKEW;
        end
      end
      SKEW: begin
        busy = 1'b1;
        if (skew_r <= SKEW_WIDTH'(1)) state_nxt = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        rd   = !bus.fifo_empty && (issued < cnt_r) && (occ < 2'd2);
        if (pop && (accepted + CNT_WIDTH'(1) == cnt_r)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt_r    <= '0;
      skew_r   <= '0;
      issued   <= '0;
      accepted <= '0;
      buf_cnt  <= '0;
      buf_q    <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd;
      if (state == IDLE && start) begin
        cnt_r    <= count;
        skew_r   <= skew;
        issued   <= '0;
        accepted <= '0;
      end
      if (state == SKEW) skew_r <= skew_r - SKEW_WIDTH'(1);
      if (rd)            issued   <= issued + CNT_WIDTH'(1);
      if (pop)           accepted <= accepted + CNT_WIDTH'(1);
      // Head holds its last word when the buffer drains so out_data never glitches to 0.
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf_q[0] <= bus.fifo_data;
          else                 buf_q[1] <= bus.fifo_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          if (buf_cnt == 2'd2) buf_q[0] <= buf_q[1];
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd2) begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= bus.fifo_data;
          end else begin
            buf_q[0] <= bus.fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_row_feeder.sv
// Directed bench for fifo_row_feeder with a behavioural fifo_mem model and event logs.
module tb_fifo_row_feeder;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic [SW-1:0] skew = '0;
  logic          busy, done;

  fifo_row_feeder_if #(.DATA_WIDTH(DW)) bus ();

  fifo_row_feeder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .SKEW_WIDTH(SW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .count(count), .skew(skew),
    .busy(busy), .done(done), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // fifo_mem model: one-cycle read latency, pointer never advances on an empty read
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk)
    if (bus.fifo_read && wr_ptr != rd_ptr) begin
      bus.fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end

  // event logs sampled mid-cycle
  logic [DW-1:0] rx[$];
  int rx_cyc[$];
  int rd_cyc[$];
  int done_cyc[$];
  int underflow_cnt = 0;
  int unstable_cnt = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (bus.fifo_read) begin
      rd_cyc.push_back(cyc);
      if (bus.fifo_empty) underflow_cnt <= underflow_cnt + 1;
    end
    if (bus.out_valid && bus.out_ready) begin
      rx.push_back(bus.out_data);
      rx_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (prev_stall && bus.out_data !== prev_data) unstable_cnt <= unstable_cnt + 1;
    prev_stall <= bus.out_valid && !bus.out_ready;
    prev_data  <= bus.out_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic int rdc(input int i);
    return (i < rd_cyc.size()) ? rd_cyc[i] : -1;
  endfunction

  function automatic int rxc(input int i);
    return (i < rx_cyc.size()) ? rx_cyc[i] : -1;
  endfunction

  function automatic logic [DW-1:0] rxd(input int i);
    return (i < rx.size()) ? rx[i] : 'x;
  endfunction

  function automatic int dnc(input int i);
    return (i < done_cyc.size()) ? done_cyc[i] : -1;
  endfunction

  task automatic wait_done(input int base, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (done_cyc.size() > base) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.out_ready = 1'b0;
    tick(); tick();
    tests++; if (bus.fifo_read !== 1'b0) begin fails++; $display("FAIL reset_fifo_read: got %b expected 0", bus.fifo_read); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    tests++; if (bus.out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic run_burst(input string name, input int sk, input logic [DW-1:0] base_val);
    int b_rd, b_rx, b_dn, s;
    bit ok;
    b_rd = rd_cyc.size(); b_rx = rx.size(); b_dn = done_cyc.size();
    for (int i = 0; i < 8; i++) push(base_val + DW'(i));
    bus.out_ready = 1'b1;
    start = 1'b1; count = 8'd8; skew = SW'(sk);
    s = cyc;
    tick();
    start = 1'b0;
    wait_done(b_dn, 60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL %s_done_timeout: got none expected done", name); end
    tick(); tick();
    tests++; if (rd_cyc.size() - b_rd != 8) begin fails++; $display("FAIL %s_read_count: got %0d expected 8", name, rd_cyc.size() - b_rd); end
    tests++; if (rdc(b_rd) != s + 1 + sk) begin fails++; $display("FAIL %s_first_read: got %0d expected %0d", name, rdc(b_rd) - s, 1 + sk); end
    tests++; if (rdc(b_rd + 7) != s + 8 + sk) begin fails++; $display("FAIL %s_last_read: got %0d expected %0d", name, rdc(b_rd + 7) - s, 8 + sk); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rxd(b_rx + i) !== base_val + DW'(i)) begin fails++; $display("FAIL %s_data%0d: got %h expected %h", name, i, rxd(b_rx + i), base_val + DW'(i)); end
    end
    tests++; if (rxc(b_rx) != s + 3 + sk) begin fails++; $display("FAIL %s_first_valid: got %0d expected %0d", name, rxc(b_rx) - s, 3 + sk); end
    tests++; if (rxc(b_rx + 7) != s + 10 + sk) begin fails++; $display("FAIL %s_last_word: got %0d expected %0d", name, rxc(b_rx + 7) - s, 10 + sk); end
    tests++; if (dnc(b_dn) != s + 11 + sk) begin fails++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, dnc(b_dn) - s, 11 + sk); end
    tests++; if (done_cyc.size() - b_dn != 1) begin fails++; $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cyc.size() - b_dn); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_after: got %b expected 0", name, busy); end
  endtask

  task automatic test_basic();
    run_burst("basic", 0, 8'h01);
  endtask

  task automatic test_skew();
    run_burst("skew", 5, 8'h11);
  endtask

  task automatic test_back_pressure();
    int b_rd, b_rx, b_dn, b_us;
    logic [3:0] pat;
    pat = 4'b1001;
    b_rd = rd_cyc.size(); b_rx = rx.size(); b_dn = done_cyc.size(); b_us = unstable_cnt;
    for (int i = 0; i < 6; i++) push(8'h21 + DW'(i));
    bus.out_ready = pat[0];
    start = 1'b1; count = 8'd6; skew = '0;
    for (int k = 1; k <= 80 && done_cyc.size() == b_dn; k++) begin
      tick();
      start = 1'b0;
      bus.out_ready = pat[2'(k)];
    end
    bus.out_ready = 1'b1;
    tick(); tick();
    tests++; if (done_cyc.size() - b_dn != 1) begin fails++; $display("FAIL bp_done: got %0d expected 1", done_cyc.size() - b_dn); end
    tests++; if (rx.size() - b_rx != 6) begin fails++; $display("FAIL bp_word_count: got %0d expected 6", rx.size() - b_rx); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (rxd(b_rx + i) !== 8'h21 + DW'(i)) begin fails++; $display("FAIL bp_data%0d: got %h expected %h", i, rxd(b_rx + i), 8'h21 + DW'(i)); end
    end
    tests++; if (unstable_cnt != b_us) begin fails++; $display("FAIL bp_stall_stable: got %0d changes expected 0", unstable_cnt - b_us); end
    tests++; if (rd_cyc.size() - b_rd != 6) begin fails++; $display("FAIL bp_read_count: got %0d expected 6", rd_cyc.size() - b_rd); end
  endtask

  task automatic test_empty_stall();
    int b_rd, b_rx, b_dn, b_uf, p;
    p = -1;
    b_rd = rd_cyc.size(); b_rx = rx.size(); b_dn = done_cyc.size(); b_uf = underflow_cnt;
    for (int i = 0; i < 3; i++) push(8'h31 + DW'(i));
    bus.out_ready = 1'b1;
    start = 1'b1; count = 8'd5; skew = '0;
    for (int k = 1; k <= 60 && done_cyc.size() == b_dn; k++) begin
      tick();
      start = 1'b0;
      if (k == 10) begin
        push(8'h34); push(8'h35);
        p = cyc;
      end
    end
    tick(); tick();
    tests++; if (underflow_cnt != b_uf) begin fails++; $display("FAIL stall_underflow: got %0d expected 0", underflow_cnt - b_uf); end
    tests++; if (rd_cyc.size() - b_rd != 5) begin fails++; $display("FAIL stall_read_count: got %0d expected 5", rd_cyc.size() - b_rd); end
    tests++; if (rdc(b_rd + 3) < p) begin fails++; $display("FAIL stall_resume: got read at %0d expected >= %0d", rdc(b_rd + 3), p); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rxd(b_rx + i) !== 8'h31 + DW'(i)) begin fails++; $display("FAIL stall_data%0d: got %h expected %h", i, rxd(b_rx + i), 8'h31 + DW'(i)); end
    end
    tests++; if (done_cyc.size() - b_dn != 1) begin fails++; $display("FAIL stall_done: got %0d expected 1", done_cyc.size() - b_dn); end
  endtask

  task automatic test_edge_starts();
    int b_rd, b_rx, b_dn;
    bit ok;
    b_rd = rd_cyc.size(); b_dn = done_cyc.size();
    bus.out_ready = 1'b1;
    start = 1'b1; count = 8'd0; skew = '0;
    tick();
    start = 1'b0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b expected 1", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b expected 0", busy); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_width: got %b expected 0", done); end
    tests++; if (rd_cyc.size() != b_rd) begin fails++; $display("FAIL zero_reads: got %0d expected 0", rd_cyc.size() - b_rd); end

    b_rd = rd_cyc.size(); b_rx = rx.size(); b_dn = done_cyc.size();
    for (int i = 0; i < 4; i++) push(8'h51 + DW'(i));
    start = 1'b1; count = 8'd4; skew = 4'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_skew: got %b expected 1", busy); end
    start = 1'b1; count = 8'd2; skew = 4'd0;
    tick();
    start = 1'b0;
    wait_done(b_dn, 60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL busy_start_timeout: got none expected done"); end
    repeat (4) tick();
    tests++; if (rx.size() - b_rx != 4) begin fails++; $display("FAIL busy_start_words: got %0d expected 4", rx.size() - b_rx); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rxd(b_rx + i) !== 8'h51 + DW'(i)) begin fails++; $display("FAIL busy_start_data%0d: got %h expected %h", i, rxd(b_rx + i), 8'h51 + DW'(i)); end
    end
    tests++; if (done_cyc.size() - b_dn != 1) begin fails++; $display("FAIL busy_start_done: got %0d expected 1", done_cyc.size() - b_dn); end
    tests++; if (rd_cyc.size() - b_rd != 4) begin fails++; $display("FAIL busy_start_reads: got %0d expected 4", rd_cyc.size() - b_rd); end
  endtask

  task automatic test_reset_mid();
    int b_rx, b_dn;
    bit ok;
    b_rx = rx.size(); b_dn = done_cyc.size();
    for (int i = 0; i < 8; i++) push(8'h41 + DW'(i));
    bus.out_ready = 1'b1;
    start = 1'b1; count = 8'd8; skew = '0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 30 && rx.size() - b_rx < 3; k++) tick();
    tests++; if (rx.size() - b_rx != 3) begin fails++; $display("FAIL mid_progress: got %0d expected 3", rx.size() - b_rx); end
    reset_n = 1'b0;
    tick();
    tests++; if (bus.fifo_read !== 1'b0) begin fails++; $display("FAIL mid_rst_fifo_read: got %b expected 0", bus.fifo_read); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_out_valid: got %b expected 0", bus.out_valid); end
    tests++; if (bus.out_data !== 8'h00) begin fails++; $display("FAIL mid_rst_out_data: got %h expected 00", bus.out_data); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mid_rst_busy_done: got %b%b expected 00", busy, done); end
    reset_n = 1'b1;
    repeat (3) tick();
    tests++; if (done_cyc.size() != b_dn) begin fails++; $display("FAIL mid_no_done: got %0d expected 0", done_cyc.size() - b_dn); end
    tests++; if (wr_ptr - rd_ptr != 2) begin fails++; $display("FAIL mid_fifo_left: got %0d expected 2", wr_ptr - rd_ptr); end
    b_rx = rx.size();
    start = 1'b1; count = 8'd2; skew = '0;
    tick();
    start = 1'b0;
    wait_done(b_dn, 40, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_restart_timeout: got none expected done"); end
    tick();
    tests++; if (rx.size() - b_rx != 2) begin fails++; $display("FAIL mid_restart_words: got %0d expected 2", rx.size() - b_rx); end
    tests++; if (rxd(b_rx) !== 8'h47) begin fails++; $display("FAIL mid_restart_data0: got %h expected 47", rxd(b_rx)); end
    tests++; if (rxd(b_rx + 1) !== 8'h48) begin fails++; $display("FAIL mid_restart_data1: got %h expected 48", rxd(b_rx + 1)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_skew();
    test_back_pressure();
    test_empty_stall();
    test_edge_starts();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
